pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform and recovers its period, high time and an R-bit-scaled duty word.
- The duty word uses the same scale as the PWM generator's duty input: 0 to 2^R in R+1 bits.
- Used for loop-back checking of the RGB PWM channels and for decoding external PWM sources.
- A sequential restoring divider converts each measurement into duty. A timeout reports stuck-high or stuck-low inputs.

Parameters:
- R, 8: duty resolution in bits; duty output is R+1 bits wide.
- CW, 32: width of the period and high-time counters.
- TIMEOUT, 1048576: clock cycles without a rising edge before a stuck condition is declared. Must satisfy R+2 <= TIMEOUT <= 2^CW-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- pwm_in  input  1  PWM signal, asynchronous to clk.
- period  output  CW  clk cycles between the last two rising edges.
- high_time  output  CW  clk cycles the input was high within that window.
- duty  output  R+1  floor(high_time*2^R/period), range 0..2^R.
- valid  output  1  one-cycle pulse; period, high_time and duty were updated this cycle.
- stuck_hi  output  1  input held high for TIMEOUT cycles.
- stuck_lo  output  1  input held low for TIMEOUT cycles.
- overrun  output  1  sticky flag: a measurement was dropped because the divider was busy.

Behaviour:
- Reset: all outputs 0, synchronizer flops 0, state IDLE, counters 0. Reset is asynchronous; all other logic is on posedge clk.
- Input conditioning:
  - 2-flop synchronizer on pwm_in, then one delay flop.
  - rise = sync & ~delayed. "Level" means the synchronized value.
  - Fixed 2-cycle input latency; no glitch filter.
- Counters:
  - cnt_p counts cycles since the last rise.
  - cnt_h counts high cycles since the last rise.
  - Both restart on every rise, so the rise cycle counts as cycle 0 of the new window.
- Definition: for rises detected at cycles t0 and t1:
  - period = t1-t0.
  - high_time = number of cycles in [t0,t1) with level high.
- State IDLE:
  - Wait for the first rise. It only arms the counters and produces no result.
  - Move to MEASURE.
- State MEASURE, on rise:
  - Latch cnt_p and cnt_h into divider operands.
  - Start dividing (high_time<<R) by period.
  - Move to DIVIDE.
- State DIVIDE:
  - Restoring division, one quotient bit per cycle, R+1 cycles.
  - Then update period, high_time and duty, and pulse valid for 1 cycle.
  - Clear stuck_hi and stuck_lo; return to MEASURE.
  - valid occurs exactly R+2 cycles after the rise cycle.
- Rise during DIVIDE:
  - The counters still restart, so window boundaries stay exact.
  - That measurement is discarded and overrun is set. overrun stays set until reset.
  - Minimum fully-reported period is R+2 cycles.
- Timeout, in IDLE or MEASURE, when cnt_p reaches TIMEOUT with no rise:
  - If level is high: stuck_hi=1, duty=2^R.
  - If level is low: stuck_lo=1, duty=0.
  - period=0, high_time=0, valid pulses once.
  - Go to IDLE; counters hold at 0 until the next rise.
  - Timeout is not evaluated in DIVIDE; cnt_p keeps counting there.
- Timeout and rise in the same cycle: rise wins, no timeout.
- Outputs hold their last values between valid pulses.
- Reset mid-DIVIDE: the result is lost and no valid is issued. After release, the first rise only arms.

Test Plan (R=8, CW=32, TIMEOUT=1000 unless stated):
1. pwm_in period 100, high 25, started after reset -> first valid 10 cycles after the 2nd rise; period=100, high_time=25, duty=64; valid repeats every 100 cycles.
2. Period 30, high 10 -> duty=85 (floor of 2560/30); period 256, high 256-1 -> duty=255; period 40, high 0 impossible -> hold low instead (see 4).
3. Waveform from scenario 1, then pwm_in held high -> 1000 cycles after the last rise: valid=1, stuck_hi=1, duty=256, period=0, high_time=0. Resuming 100/25 -> second rise gives duty=64 and stuck_hi=0.
4. pwm_in low from reset release -> valid at 1000 cycles after counting starts: stuck_lo=1, duty=0. No further valid while low.
5. Period 6, high 3 (below R+2=10) -> overrun=1; every reported result has period=6, high_time=3, duty=128; overrun remains 1.
6. Assert rst 4 cycles into DIVIDE -> all outputs 0, no valid. Restart 100/50 -> no result on 1st rise; duty=128 after 2nd rise.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: recovers period, high time and an R-bit duty word via a restoring divider.
// Latency: valid R+2 cycles after a rise (2 more for input sync); no backpressure, rises while busy set overrun.
module pwm_capture #(
  parameter int R       = 8,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1048576
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic [R:0]    duty,
  output logic          valid,
  output logic          stuck_hi,
  output logic          stuck_lo,
  output logic          overrun
);

  localparam int SW = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
  logic [CW-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
  logic          hold_q, hold_d;
  logic [CW-1:0] den_q, den_d, hlat_q, hlat_d, rem_q, rem_d;
  logic [R-1:0]  quo_q, quo_d;
  logic          nbit_q, nbit_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] period_q, period_d, high_q, high_d;
  logic [R:0]    duty_q, duty_d;
  logic          valid_q, valid_d, stuck_hi_q, stuck_hi_d, stuck_lo_q, stuck_lo_d;
  logic          overrun_q, overrun_d;

  logic          level, rise, timeout, ge;
  logic [CW:0]   trial, diff;

  assign level = sync2_q;
  assign rise  = sync2_q & ~dly_q;
  // Rise beats timeout; once timed out, counters are parked at 0 until the next rise.
  assign timeout = (state_q != DIVIDE) && !hold_q && !rise && (cnt_p_q >= CW'(TIMEOUT));
  assign trial = {rem_q, nbit_q};
  assign diff  = trial - {1'b0, den_q};
  assign ge    = (trial >= {1'b0, den_q});

  always_comb begin
    state_d    = state_q;
    sync1_d    = pwm_in;
    sync2_d    = sync1_q;
    dly_d      = sync2_q;
    cnt_p_d    = cnt_p_q;
    cnt_h_d    = cnt_h_q;
    hold_d     = hold_q;
    den_d      = den_q;
    hlat_d     = hlat_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    nbit_d     = nbit_q;
    step_d     = step_q;
    period_d   = period_q;
    high_d     = high_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    overrun_d  = overrun_q;

    if (rise) begin
      cnt_p_d = CW'(1);
      cnt_h_d = CW'(1);
      hold_d  = 1'b0;
    end else if (timeout || hold_q) begin
      cnt_p_d = '0;
      cnt_h_d = '0;
    end else begin
      cnt_p_d = cnt_p_q + CW'(1);
      cnt_h_d = cnt_h_q + CW'(level);
    end

    if (timeout) begin
      hold_d     = 1'b1;
      valid_d    = 1'b1;
      period_d   = '0;
      high_d     = '0;
      stuck_hi_d = level;
      stuck_lo_d = ~level;
      duty_d     = level ? {1'b1, {R{1'b0}}} : '0;
      state_d    = IDLE;
    end

    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          // high < period, so (high>>1) is already a valid partial remainder.
          den_d   = cnt_p_q;
          hlat_d  = cnt_h_q;
          rem_d   = cnt_h_q >> 1;
          nbit_d  = cnt_h_q[0];
          quo_d   = '0;
          step_d  = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d  = ge ? diff[CW-1:0] : trial[CW-1:0];
        quo_d  = {quo_q[R-2:0], ge};
        nbit_d = 1'b0;
        step_d = step_q + SW'(1);
        if (rise) overrun_d = 1'b1;
        if (step_q == SW'(R)) begin
          period_d   = den_q;
          high_d     = hlat_q;
          duty_d     = {quo_q, ge};
          valid_d    = 1'b1;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
          state_d    = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      cnt_p_q    <= '0;
      cnt_h_q    <= '0;
      hold_q     <= 1'b0;
      den_q      <= '0;
      hlat_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      nbit_q     <= 1'b0;
      step_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dly_q      <= dly_d;
      cnt_p_q    <= cnt_p_d;
      cnt_h_q    <= cnt_h_d;
      hold_q     <= hold_d;
      den_q      <= den_d;
      hlat_q     <= hlat_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      nbit_q     <= nbit_d;
      step_q     <= step_d;
      period_q   <= period_d;
      high_q     <= high_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
      overrun_q  <= overrun_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign stuck_hi  = stuck_hi_q;
  assign stuck_lo  = stuck_lo_q;
  assign overrun   = overrun_q;

endmodule
